// File: rtl/wasm_pkg.sv
// Shared WASM definitions: section ids, header bytes, loader error codes and FSM states.
package wasm_pkg;

    localparam logic [7:0]  SEC_IMPORT  = 8'd2;
    localparam logic [7:0]  SEC_START   = 8'd8;
    localparam logic [7:0]  SEC_CODE    = 8'd10;
    // Magic "\0asm" followed by version 1, in file order.
    localparam logic [63:0] WASM_HEADER = 64'h0061736D_01000000;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_MAGIC     = 3'd1,
        ERR_VERSION   = 3'd2,
        ERR_LEB       = 3'd3,
        ERR_IMPORT    = 3'd4,
        ERR_TRUNC     = 3'd5,
        ERR_START_IDX = 3'd6
    } err_e;

    typedef enum logic [3:0] {
        ST_MAGIC,
        ST_SEC_ID,
        ST_SEC_SIZE,
        ST_SKIP,
        ST_START_IDX,
        ST_CODE_COUNT,
        ST_BODY_SIZE,
        ST_BODY_SKIP,
        ST_LOCAL_COUNT,
        ST_LOCAL_N,
        ST_LOCAL_TYPE,
        ST_DONE,
        ST_ERROR
    } state_e;

    function automatic logic [7:0] header_byte(input logic [2:0] idx);
        return WASM_HEADER[8*(7 - int'(idx)) +: 8];
    endfunction

endpackage

// File: rtl/wasm_leb128_u32.sv
// Unsigned LEB128 (u32) accumulator; value/done/overflow describe the field including the byte presented now.
import wasm_pkg::*;

module wasm_leb128_u32 #(
    parameter int MAX_LEB = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] value_o,
    output logic        done_o,
    output logic        overflow_o
);

    logic [31:0] acc_q, acc_d;
    logic [2:0]  k_q, k_d;
    logic [31:0] payload;
    logic [4:0]  shamt;
    logic        last_k;

    always_comb begin
        shamt      = 5'(7 * k_q);
        payload    = {25'd0, byte_i[6:0]} << shamt;
        last_k     = (k_q == 3'(MAX_LEB - 1));
        value_o    = acc_q | payload;
        // The final byte of a u32 may carry only 4 payload bits and no continuation.
        overflow_o = byte_valid_i && last_k && (byte_i[7] || (byte_i[6:4] != 3'd0));
        done_o     = byte_valid_i && !byte_i[7] && !overflow_o;

        acc_d = acc_q;
        k_d   = k_q;
        if (clear_i) begin
            acc_d = 32'd0;
            k_d   = 3'd0;
        end else if (byte_valid_i) begin
            if (done_o || overflow_o) begin
                acc_d = 32'd0;
                k_d   = 3'd0;
            end else begin
                acc_d = value_o;
                k_d   = k_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 32'd0;
            k_q   <= 3'd0;
        end else begin
            acc_q <= acc_d;
            k_q   <= k_d;
        end
    end

endmodule

// File: rtl/wasm_loader.sv
// Boot-time WASM parser: validates the header, walks sections over the byte-wide ROM port and
// reports the offset of the start function's first opcode.
import wasm_pkg::*;

module wasm_loader #(
    parameter logic [31:0] ROM_BASE = 32'h0,
    parameter int unsigned ROM_SIZE = 65536,
    parameter int          MAX_LEB  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] addr,
    output logic        memory_read_en,
    input  logic [7:0]  data_out,
    input  logic        memory_ready,
    output logic        rom_mapped,
    output logic [31:0] first_instruction,
    output logic        parse_error,
    output logic [2:0]  error_code
);

    state_e      state_q;
    err_e        err_q;
    logic [31:0] offset_q;
    logic [31:0] start_idx_q;
    logic [31:0] size_q;
    logic [31:0] body_idx_q;
    logic [31:0] locals_q;
    logic [31:0] first_instr_q;
    logic [7:0]  sec_id_q;
    logic [2:0]  hdr_idx_q;
    logic        read_en_q;
    logic        rom_mapped_q;
    logic        parse_error_q;

    logic        need_byte, leb_active, capture, leb_valid;
    logic        leb_done, leb_ovf, at_bound, skip_bad;
    logic [31:0] leb_value;
    logic [32:0] skip_sum;
    logic        err_hit;
    err_e        err_val;

    assign need_byte  = state_q inside {ST_MAGIC, ST_SEC_ID, ST_SEC_SIZE, ST_START_IDX,
                                        ST_CODE_COUNT, ST_BODY_SIZE, ST_LOCAL_COUNT,
                                        ST_LOCAL_N, ST_LOCAL_TYPE};
    assign leb_active = state_q inside {ST_SEC_SIZE, ST_START_IDX, ST_CODE_COUNT,
                                        ST_BODY_SIZE, ST_LOCAL_COUNT, ST_LOCAL_N};
    assign capture    = read_en_q && memory_ready;
    assign leb_valid  = capture && leb_active;
    assign at_bound   = offset_q >= 32'(ROM_SIZE);
    // A carry out of bit 31 always exceeds ROM_SIZE, so one compare covers both cases.
    assign skip_sum   = {1'b0, offset_q} + {1'b0, size_q};
    assign skip_bad   = skip_sum > 33'(ROM_SIZE);

    wasm_leb128_u32 #(
        .MAX_LEB (MAX_LEB)
    ) u_leb (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (!leb_active),
        .byte_valid_i (leb_valid),
        .byte_i       (data_out),
        .value_o      (leb_value),
        .done_o       (leb_done),
        .overflow_o   (leb_ovf)
    );

    always_comb begin
        err_hit = 1'b0;
        err_val = ERR_NONE;
        if (need_byte && !read_en_q && at_bound) begin
            err_hit = 1'b1;
            err_val = ERR_TRUNC;
        end else if (leb_ovf) begin
            err_hit = 1'b1;
            err_val = ERR_LEB;
        end else if (capture && state_q == ST_MAGIC && data_out != header_byte(hdr_idx_q)) begin
            err_hit = 1'b1;
            err_val = (hdr_idx_q < 3'd4) ? ERR_MAGIC : ERR_VERSION;
        end else if (leb_done && state_q == ST_SEC_SIZE && sec_id_q == SEC_IMPORT) begin
            err_hit = 1'b1;
            err_val = ERR_IMPORT;
        end else if (leb_done && state_q == ST_CODE_COUNT && start_idx_q >= leb_value) begin
            err_hit = 1'b1;
            err_val = ERR_START_IDX;
        end else if ((state_q == ST_SKIP || state_q == ST_BODY_SKIP) && skip_bad) begin
            err_hit = 1'b1;
            err_val = ERR_TRUNC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_MAGIC;
            err_q         <= ERR_NONE;
            offset_q      <= 32'd0;
            start_idx_q   <= 32'd0;
            size_q        <= 32'd0;
            body_idx_q    <= 32'd0;
            locals_q      <= 32'd0;
            first_instr_q <= 32'd0;
            sec_id_q      <= 8'd0;
            hdr_idx_q     <= 3'd0;
            read_en_q     <= 1'b0;
            rom_mapped_q  <= 1'b0;
            parse_error_q <= 1'b0;
        end else if (err_hit) begin
            state_q       <= ST_ERROR;
            err_q         <= err_val;
            parse_error_q <= 1'b1;
            read_en_q     <= 1'b0;
        end else begin
            // Requests start only once ready is seen low, so a stale ready never completes a read.
            if (need_byte && !read_en_q && !memory_ready) begin
                read_en_q <= 1'b1;
            end
            if (capture) begin
                read_en_q <= 1'b0;
                offset_q  <= offset_q + 32'd1;
            end

            case (state_q)
                ST_MAGIC: if (capture) begin
                    if (hdr_idx_q == 3'd7) state_q <= ST_SEC_ID;
                    else                   hdr_idx_q <= hdr_idx_q + 3'd1;
                end
                ST_SEC_ID: if (capture) begin
                    sec_id_q <= data_out;
                    state_q  <= ST_SEC_SIZE;
                end
                ST_SEC_SIZE: if (leb_done) begin
                    size_q <= leb_value;
                    case (sec_id_q)
                        SEC_START: state_q <= ST_START_IDX;
                        SEC_CODE:  state_q <= ST_CODE_COUNT;
                        default:   state_q <= ST_SKIP;
                    endcase
                end
                ST_SKIP: begin
                    offset_q <= skip_sum[31:0];
                    state_q  <= ST_SEC_ID;
                end
                ST_START_IDX: if (leb_done) begin
                    start_idx_q <= leb_value;
                    state_q     <= ST_SEC_ID;
                end
                ST_CODE_COUNT: if (leb_done) begin
                    body_idx_q <= 32'd0;
                    state_q    <= ST_BODY_SIZE;
                end
                ST_BODY_SIZE: if (leb_done) begin
                    size_q <= leb_value;
                    if (body_idx_q != start_idx_q) state_q <= ST_BODY_SKIP;
                    else                           state_q <= ST_LOCAL_COUNT;
                end
                ST_BODY_SKIP: begin
                    offset_q   <= skip_sum[31:0];
                    body_idx_q <= body_idx_q + 32'd1;
                    state_q    <= ST_BODY_SIZE;
                end
                ST_LOCAL_COUNT: if (leb_done) begin
                    locals_q <= leb_value;
                    if (leb_value == 32'd0) state_q <= ST_DONE;
                    else                    state_q <= ST_LOCAL_N;
                end
                ST_LOCAL_N: if (leb_done) begin
                    state_q <= ST_LOCAL_TYPE;
                end
                ST_LOCAL_TYPE: if (capture) begin
                    locals_q <= locals_q - 32'd1;
                    if (locals_q == 32'd1) state_q <= ST_DONE;
                    else                   state_q <= ST_LOCAL_N;
                end
                ST_DONE: begin
                    first_instr_q <= offset_q;
                    rom_mapped_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign addr              = ROM_BASE + offset_q;
    assign memory_read_en    = read_en_q;
    assign rom_mapped        = rom_mapped_q;
    assign first_instruction = first_instr_q;
    assign parse_error       = parse_error_q;
    assign error_code        = err_q;

endmodule
